// File: rtl/fpwb_pkg.sv
// Shared types for the FP multiplier writeback merge.
//   wb_size_e  : register-file write size encoding
//   FLAG_*     : bit positions inside the 4-bit result flag vector
//   wb_entry_t : one queued writeback, {tag, size, data, flags} = 138 bits
package fpwb_pkg;

    typedef enum logic [1:0] {
        SZ32  = 2'b00,
        SZ64  = 2'b01,
        SZ128 = 2'b10
    } wb_size_e;

    localparam int FLAG_ZERO = 0;
    localparam int FLAG_SIGN = 1;
    localparam int FLAG_INF  = 2;
    localparam int FLAG_NAN  = 3;

    typedef struct packed {
        logic [3:0]   tag;
        wb_size_e     size;
        logic [127:0] data;
        logic [3:0]   flags;
    } wb_entry_t;

endpackage

// File: rtl/fpwb_fifo2w.sv
// Circular buffer with two write ports and one read port.
//   CLK, RESET    : clock, synchronous active-high reset
//   i_push0/1     : write enables; entry1 lands in the slot after entry0
//   i_entry0/1    : entries to store
//   i_pop         : remove the head entry this edge
//   o_head        : head slot contents (undefined while o_empty)
//   o_empty       : no entries stored
//   o_free        : slots available this cycle, counting a same-cycle pop
//   o_count_next  : occupancy after this edge
module fpwb_fifo2w
    import fpwb_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          i_push0,
    input  wb_entry_t     i_entry0,
    input  logic          i_push1,
    input  wb_entry_t     i_entry1,
    input  logic          i_pop,
    output wb_entry_t     o_head,
    output logic          o_empty,
    output logic [CW-1:0] o_free,
    output logic [CW-1:0] o_count_next
);

    wb_entry_t       r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic [AW-1:0]   w_wr_slot1;

    // Second write goes right after the first one; pointers wrap naturally
    // because DEPTH is a power of two.
    assign w_wr_slot1   = r_wr_ptr + AW'(i_push0);
    assign o_head       = r_mem[r_rd_ptr];
    assign o_empty      = (r_count == '0);
    assign o_free       = CW'(DEPTH) - r_count + CW'(i_pop);
    assign o_count_next = r_count + CW'(i_push0) + CW'(i_push1) - CW'(i_pop);

    // NOTE: storage is deliberately not reset; occupancy is defined by the
    // pointers and count, so stale slot contents are never observed.
    always_ff @(posedge CLK) begin
        if (i_push0) r_mem[r_wr_ptr]   <= i_entry0;
        if (i_push1) r_mem[w_wr_slot1] <= i_entry1;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + AW'(i_push0) + AW'(i_push1);
            r_rd_ptr <= r_rd_ptr + AW'(i_pop);
            r_count  <= o_count_next;
        end
    end

endmodule

// File: rtl/fpmul_wb_merge.sv
// Merges the FP multiplier's SD and Q result channels into one
// register-file write port with valid/ready backpressure, and keeps
// sticky {OVF,NAN,INF} status.
//   CLK, RESET             : clock, synchronous active-high reset
//   RDYSD/DSTSD/RSD/SR     : SD channel valid, tag, data, size (0=32, 1=64)
//   ZEROSD..NANSD          : SD result flags
//   RDYQ/DSTQ/RQ           : Q channel valid, tag, 128-bit data
//   ZEROQ..NANQ            : Q result flags
//   WVALID/WRDY            : write request / accept
//   WDST/WSIZE/WDATA/WFLAGS: head entry fields ({NAN,INF,SIGN,ZERO})
//   AFULL                  : registered, occupancy >= AFULL_LEVEL
//   STICKY                 : {OVF,NAN,INF}; FCLR clears, new sets win
module fpmul_wb_merge
    import fpwb_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int AFULL_LEVEL = 6,
    localparam int CW         = $clog2(DEPTH) + 1
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         RDYSD,
    input  logic [3:0]   DSTSD,
    input  logic [63:0]  RSD,
    input  logic         SR,
    input  logic         ZEROSD,
    input  logic         SIGNSD,
    input  logic         INFSD,
    input  logic         NANSD,
    input  logic         RDYQ,
    input  logic [3:0]   DSTQ,
    input  logic [127:0] RQ,
    input  logic         ZEROQ,
    input  logic         SIGNQ,
    input  logic         INFQ,
    input  logic         NANQ,
    output logic         WVALID,
    input  logic         WRDY,
    output logic [3:0]   WDST,
    output logic [1:0]   WSIZE,
    output logic [127:0] WDATA,
    output logic [3:0]   WFLAGS,
    output logic         AFULL,
    output logic [2:0]   STICKY,
    input  logic         FCLR
);

    wb_entry_t     w_sd_entry, w_q_entry, w_entry0, w_entry1, w_head;
    logic          w_arr0, w_arr1, w_push0, w_push1, w_pop, w_empty;
    logic [CW-1:0] w_free, w_count_next;
    logic [2:0]    w_sticky_set;
    logic          r_afull;
    logic [2:0]    r_sticky;

    always_comb begin
        w_sd_entry.tag   = DSTSD;
        w_sd_entry.size  = SR ? SZ64 : SZ32;
        w_sd_entry.data  = SR ? {64'd0, RSD} : {96'd0, RSD[31:0]};
        w_sd_entry.flags = {NANSD, INFSD, SIGNSD, ZEROSD};
        w_q_entry.tag    = DSTQ;
        w_q_entry.size   = SZ128;
        w_q_entry.data   = RQ;
        w_q_entry.flags  = {NANQ, INFQ, SIGNQ, ZEROQ};
    end

    // Slot 0 always carries the older operation: Q when it arrives, so a
    // simultaneous SD lands behind it and is the one dropped on overflow.
    // NOTE: every always_comb output gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        w_entry0 = w_sd_entry;
        w_entry1 = w_sd_entry;
        w_arr0   = RDYSD;
        w_arr1   = 1'b0;
        if (RDYQ) begin
            w_entry0 = w_q_entry;
            w_arr0   = 1'b1;
            w_arr1   = RDYSD;
        end
    end

    assign w_pop   = !w_empty && WRDY;
    assign w_push0 = w_arr0 && (w_free != '0);
    assign w_push1 = w_arr1 && (w_free >= CW'(2));

    assign w_sticky_set[2] = (w_arr0 && !w_push0) || (w_arr1 && !w_push1);
    assign w_sticky_set[1] = (w_push0 && w_entry0.flags[FLAG_NAN]) ||
                             (w_push1 && w_entry1.flags[FLAG_NAN]);
    assign w_sticky_set[0] = (w_push0 && w_entry0.flags[FLAG_INF]) ||
                             (w_push1 && w_entry1.flags[FLAG_INF]);

    fpwb_fifo2w #(.DEPTH(DEPTH)) u_fifo (
        .CLK          (CLK),
        .RESET        (RESET),
        .i_push0      (w_push0),
        .i_entry0     (w_entry0),
        .i_push1      (w_push1),
        .i_entry1     (w_entry1),
        .i_pop        (w_pop),
        .o_head       (w_head),
        .o_empty      (w_empty),
        .o_free       (w_free),
        .o_count_next (w_count_next)
    );

    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_afull  <= 1'b0;
            r_sticky <= '0;
        end else begin
            r_afull  <= (w_count_next >= CW'(AFULL_LEVEL));
            r_sticky <= FCLR ? w_sticky_set : (r_sticky | w_sticky_set);
        end
    end

    // Head fields are masked while empty so unwritten storage never leaks.
    assign WVALID = !w_empty;
    assign WDST   = w_empty ? '0 : w_head.tag;
    assign WSIZE  = w_empty ? '0 : w_head.size;
    assign WDATA  = w_empty ? '0 : w_head.data;
    assign WFLAGS = w_empty ? '0 : w_head.flags;
    assign AFULL  = r_afull;
    assign STICKY = r_sticky;

endmodule

// File: doc/fpmul_wb_merge.md
Name: fpmul_wb_merge

Overview:
- Writeback stage directly downstream of the 128-bit FP multiplier.
- The multiplier has two fixed-latency result channels: a 32/64-bit (SD) channel and a 128-bit (Q) channel. These cannot be stalled, and they can complete in the same cycle.
- This block merges both channels into a FIFO and drains it through one register-file write port with valid/ready backpressure.
- It also maintains sticky exception flags for the FP status register.

Parameters:
DEPTH, 8, FIFO entries (power of two, >=4)
AFULL_LEVEL, 6, entry count at or above which AFULL asserts (issue logic stops issuing multiplies)

Ports:
CLK  in  1  clock
RESET  in  1  synchronous reset, active-high
RDYSD  in  1  SD result valid (single-cycle pulse)
DSTSD  in  4  SD destination register tag
RSD  in  64  SD result; for 32-bit results only [31:0] is meaningful
SR  in  1  SD size: 0=32-bit, 1=64-bit
ZEROSD, SIGNSD, INFSD, NANSD  in  1 each  SD result flags
RDYQ  in  1  Q result valid (single-cycle pulse)
DSTQ  in  4  Q destination tag
RQ  in  128  Q result
ZEROQ, SIGNQ, INFQ, NANQ  in  1 each  Q result flags
WVALID  out  1  write port request
WRDY  in  1  register file accepts the write
WDST  out  4  write tag
WSIZE  out  2  00=32, 01=64, 10=128
WDATA  out  128  write data, zero-extended
WFLAGS  out  4  {NAN,INF,SIGN,ZERO} of the head entry
AFULL  out  1  count >= AFULL_LEVEL
STICKY  out  3  {OVF,NAN,INF} sticky status
FCLR  in  1  clear STICKY

Behaviour:
- Reset: all outputs 0, FIFO empty, count 0, pointers 0. A reset mid-drain discards every entry and ignores same-cycle RDY inputs.
- Entry format: {tag[3:0], size[1:0], data[127:0], flags[3:0]} = 138 bits.
- Packing on push:
  - SD with SR=0 -> size 00, data = {96'd0, RSD[31:0]}.
  - SD with SR=1 -> size 01, data = {64'd0, RSD}.
  - Q -> size 10, data = RQ.
- Push latency: an entry pushed at edge N is visible on WVALID/W* after edge N (1-cycle latency into an empty FIFO). There is no combinational bypass from inputs to outputs.
- Output timing: W* is driven from the head slot. WVALID = !empty.
- Pop rule: a pop occurs on an edge where WVALID & WRDY. While WVALID=1 and WRDY=0, W* hold stable.
- Simultaneous arrival: both RDYSD and RDYQ in one cycle -> two pushes that cycle. The Q entry is written at wr_ptr and the SD entry at wr_ptr+1, so the Q operation (issued earlier) drains first.
- Count update: count_next = count + pushes - pop, with pushes in 0..2 and pop in 0..1. Pop and push in the same cycle on a full FIFO is legal: the pop frees a slot before the push is evaluated.
- Free slots: free = DEPTH - count + pop.
- Overflow, free=0: all arriving entries are dropped and STICKY[2] (OVF) sets.
- Overflow, free=1 with two arrivals: Q is stored, SD is dropped, OVF sets.
- Pointers wrap modulo DEPTH. Count width is clog2(DEPTH)+1.
- AFULL is registered and reflects count after the edge.
- Sticky flags:
  - STICKY[1] sets on push of any accepted entry with NAN=1.
  - STICKY[0] sets on push of any accepted entry with INF=1.
  - Dropped entries do not set NAN or INF.
  - FCLR clears all three bits. Same-cycle set and FCLR -> set wins.
- Input flag contract: RDYSD/RDYQ are pulses. Flags, data and tags are sampled only when the matching RDY is 1.

Decomposition:
- Package fpwb_pkg holds:
  - size enum: SZ32=2'b00, SZ64=2'b01, SZ128=2'b10.
  - flag bit indices.
  - packed struct wb_entry_t (tag, size, data, flags).
- One sub-module, fpwb_fifo2w: a 2-write/1-read circular buffer holding the storage, pointers and count. It takes push0/push1 enables and outputs free count. The top level does packing, drop decisions, AFULL and sticky flags.

Test Plan:
1. Single SD push: RDYSD=1, DSTSD=3, SR=0, RSD=64'h0000_0000_3F80_0000, WRDY=1 -> next cycle WVALID=1, WDST=3, WSIZE=00, WDATA=128'h3F80_0000. The entry pops on that edge, and WVALID=0 the cycle after.
2. Simultaneous arrival: RDYQ=1 (DSTQ=7, RQ=128'h3FFF_0...0) with RDYSD=1 (DSTSD=2, SR=1, RSD=64'h4000_0000_0000_0000), WRDY=1 -> WDST=7, WSIZE=10 first, then WDST=2, WSIZE=01, WDATA=128'h0...0_4000_0000_0000_0000.
3. Backpressure and fill: WRDY=0 with 6 SD pushes -> AFULL=1 after the 6th edge. Outputs stay frozen on the first entry.
4. Overflow: 7 queued entries, WRDY=0, then both channels fire -> Q is stored, SD is dropped, STICKY=3'b100. FCLR -> STICKY=0.
5. Full with drain: count=8, WRDY=1, RDYSD=1 -> one pop and one push, count stays 8, no OVF.
6. Flags and reset: push Q with NANQ=1 -> STICKY[1]=1, WFLAGS=4'b1000. Assert RESET with 3 entries queued -> next cycle WVALID=0, AFULL=0, STICKY=0.
